// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-addressed 16-bit data memory with a req/ready
// handshake and a fixed number of wait states before each access.
// Operands are captured when a request is accepted. Out-of-range accesses
// are flagged and never touch the array.
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   req, we      : access request (sampled at an edge), 1 = write
//   addr, wdata  : word address and write data
//   rdata        : read data to the MDR, held until the next completed read
//   ready        : one-cycle completion pulse
//   busy         : high while an access is in progress
//   err          : out-of-range flag, pulses together with ready
module data_memory_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                mem_we_c;
  logic                oor_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Captured address has bits set above the array index.
  assign oor_c = (addr_q >> ADDR_W) != 16'h0000;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    mem_we_c = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Access edge: completion flags are registered into DONE.
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = oor_c;
          if (we_q) begin
            mem_we_c = ~oor_c;
          end else begin
            rdata_d = oor_c ? 16'h0000 : mem[addr_q[ADDR_W-1:0]];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array, not reset; written only from captured operands.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q == S_BUSY);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed scenarios plus randomized accesses on a
// WAIT_CYCLES=2 instance (A) and a WAIT_CYCLES=0 instance (B), checked against
// a transaction-level model (word array, last read value, expected latency).
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, ready_a, busy_a, err_a;
  logic [15:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ready_b, busy_b, err_b;
  logic [15:0] addr_b, wdata_b, rdata_b;

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .err(err_a)
  );

  data_memory_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .err(err_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: per-instance word store and last read value.
  logic [15:0] mdl_mem [2][256];
  bit          mdl_vld [2][256];
  logic [15:0] mdl_rd  [2];
  bit          mdl_rd_ok [2];
  int          mdl_wait [2];
  longint      last_rdy_t [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? err_a : err_b;
  endfunction
  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? rdata_a : rdata_b;
  endfunction

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mdl_rd[s]    = 16'h0000;
      mdl_rd_ok[s] = 1'b1;
    end
  endtask

  // One access; called and returns at posedge+1. With hold=1 req stays high
  // and garbage operands are driven during BUSY, so a follow-up call made at
  // once is accepted at the edge ending DONE.
  task automatic access(input int sel, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input bit hold);
    int n;
    bit oor;
    oor = (a >= 16'd256);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk); #1;
    if (w && !oor) begin
      mdl_mem[sel][a[7:0]] = d;
      mdl_vld[sel][a[7:0]] = 1'b1;
    end
    if (!w) begin
      if (oor) begin
        mdl_rd[sel] = 16'h0000; mdl_rd_ok[sel] = 1'b1;
      end else begin
        mdl_rd[sel] = mdl_mem[sel][a[7:0]]; mdl_rd_ok[sel] = mdl_vld[sel][a[7:0]];
      end
    end
    if (!hold) drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n = 0;
    while (get_ready(sel) !== 1'b1 && n < 20) begin
      check("busy_during_access", 32'(get_busy(sel)), 32'd1);
      if (hold) drive(sel, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      n++;
    end
    last_rdy_t[sel] = longint'($time);
    check("latency", 32'(n), 32'(mdl_wait[sel] + 1));
    check("busy_in_done", 32'(get_busy(sel)), 32'd0);
    check("err", 32'(get_err(sel)), 32'(oor));
    if (mdl_rd_ok[sel]) check("rdata", 32'(get_rdata(sel)), 32'(mdl_rd[sel]));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    longint prev_t;
    mdl_wait[0] = 2;
    mdl_wait[1] = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) mdl_vld[s][i] = 1'b0;
    model_reset();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdata", 32'(rdata_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);

    // Write 977 to word 5, then read it back and watch it hold.
    access(0, 1'b1, 16'h0005, 16'd977, 1'b0);
    idle(1);
    check("ready_one_cycle", 32'(ready_a), 32'd0);
    access(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    check("read_977", 32'(rdata_a), 32'd977);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("rdata_hold", 32'(rdata_a), 32'd977);
    end

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rdata", 32'(rdata_a), 32'd0);
    check("async_rst_ready", 32'(ready_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_err", 32'(err_a), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Reset while in DONE of an out-of-range access clears ready/err at once.
    access(0, 1'b0, 16'h0105, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("done_rst_ready", 32'(ready_a), 32'd0);
    check("done_rst_err", 32'(err_a), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Back-to-back with req held; operands toggled during BUSY.
    access(0, 1'b1, 16'h0001, 16'd54, 1'b1);
    prev_t = last_rdy_t[0];
    access(0, 1'b1, 16'h0002, 16'd6516, 1'b1);
    check("b2b_period_1", 32'(last_rdy_t[0] - prev_t), 32'd40);
    prev_t = last_rdy_t[0];
    access(0, 1'b0, 16'h0001, 16'h0000, 1'b1);
    check("b2b_period_2", 32'(last_rdy_t[0] - prev_t), 32'd40);
    check("b2b_rd_54", 32'(rdata_a), 32'd54);
    prev_t = last_rdy_t[0];
    access(0, 1'b0, 16'h0002, 16'h0000, 1'b0);
    check("b2b_period_3", 32'(last_rdy_t[0] - prev_t), 32'd40);
    check("b2b_rd_6516", 32'(rdata_a), 32'd6516);
    idle(1);

    // Out-of-range write must not alias onto word 5.
    access(0, 1'b1, 16'h0105, 16'hBEEF, 1'b0);
    check("oor_wr_ready", 32'(ready_a), 32'd1);
    idle(1);
    access(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    check("oor_no_alias", 32'(rdata_a), 32'd977);
    idle(1);
    access(0, 1'b0, 16'h0105, 16'h0000, 1'b0);
    check("oor_rd_zero", 32'(rdata_a), 32'd0);
    idle(1);
    check("oor_err_one_cycle", 32'(err_a), 32'd0);

    // Reset one cycle before the access edge aborts the write of 333.
    drive(0, 1'b1, 1'b1, 16'h0005, 16'd333);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    check("abort_no_ready", 32'(ready_a), 32'd0);
    access(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    check("abort_keeps_977", 32'(rdata_a), 32'd977);
    idle(1);

    // Zero wait-state instance.
    access(1, 1'b1, 16'h00FF, 16'd1804, 1'b0);
    idle(1);
    access(1, 1'b0, 16'h00FF, 16'h0000, 1'b0);
    check("w0_read_1804", 32'(rdata_b), 32'd1804);
    idle(1);

    // Randomized accesses on both instances.
    for (int i = 0; i < 60; i++) begin
      int          sel;
      logic [15:0] a;
      sel = int'($urandom_range(0, 1));
      a   = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = a | (16'($urandom_range(1, 255)) << 8);
      access(sel, 1'($urandom), a, 16'($urandom), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
